ps2_scan_rx: RTL and testbench
==============================

// Module: ps2_scan_rx
// PURPOSE
//   PS/2 keyboard receive stage: turns raw kbdclk/kbddat into whole scan-code bytes.
//   Synchronises the lines, frames 11-bit device-to-host packets and checks odd parity.
//   Also tags break (F0) and extended (E0) prefixes.
//   Sits directly upstream of the scan-code-to-letter decoder, which consumes keycode.
//   keycode is a held level that changes only on an accepted byte.
// PARAMETERS
//   CLK_HZ       100_000_000  system clock frequency; sets the timeout cycle count
//   TIMEOUT_US   200          max gap between PS/2 falling edges inside one frame
//   FILTER_LEN   8            sys-clk cycles kbdclk must hold a level before it is accepted
// PORTS
//   clk          in   1   system clock; all logic on posedge
//   rst          in   1   synchronous, active-high reset
//   kbdclk       in   1   raw PS/2 clock from the connector (asynchronous)
//   kbddat       in   1   raw PS/2 data from the connector (asynchronous)
//   keycode      out  8   last accepted byte; holds until the next accepted byte
//   code_valid   out  1   1-cycle pulse when keycode is updated
//   is_break     out  1   1 when the current keycode followed an F0 prefix
//   is_extended  out  1   1 when the current keycode followed an E0 prefix
//   frame_err    out  1   1-cycle pulse on parity, stop-bit or timeout failure
// BEHAVIOUR
//   Reset:
//   - keycode=8'h00; code_valid, is_break, is_extended, frame_err = 0.
//   - FSM goes to IDLE; prefix flags, bit counter and timeout counter clear.
//   - Reset asserted mid-frame discards the partial frame.
//   Input conditioning:
//   - 2-FF synchronisers on both lines.
//   - Filtered kbdclk changes only after FILTER_LEN equal consecutive samples.
//   - fall = filtered kbdclk 1->0.
//   - Data is sampled from synced kbddat in the cycle fall is high.
//   FSM:
//   - IDLE:   fall & dat=0 -> DATA, bit_cnt=0. fall & dat=1 -> stay, no error.
//   - DATA:   on each fall, shift = {dat, shift[7:1]} (LSB first); bit_cnt++.
//             After the 8th bit -> PARITY.
//   - PARITY: on fall, latch dat as par -> STOP.
//   - STOP:   on fall, evaluate:
//             ok  = dat==1 & (^shift ^ par)==1.
//             ok  -> ACCEPT.
//             !ok -> frame_err=1 for 1 cycle, clear prefix flags -> IDLE.
//   - ACCEPT (one cycle):
//     - keycode<=shift; code_valid=1.
//     - shift==8'hF0: set brk_pend; outputs is_break=0, is_extended=ext_pend.
//     - shift==8'hE0: set ext_pend; outputs is_break=0, is_extended=0.
//     - any other byte: is_break<=brk_pend, is_extended<=ext_pend; then clear both pends.
//     - Then -> IDLE.
//     - Prefix bytes are still emitted, so the decoder sees F0 and AA as today.
//   Latency: code_valid rises 1 cycle after the cycle in which the stop-bit fall is detected.
//   Timeout:
//   - Counter clears on every fall; it counts only while state != IDLE.
//   - Reaching TIMEOUT_US*CLK_HZ/1e6 -> frame_err pulse, clear prefix flags -> IDLE.
//   Simultaneous events:
//   - rst dominates everything.
//   - A timeout and a fall in the same cycle: the fall wins and the counter clears.
//   Errors leave keycode, is_break and is_extended unchanged.
//   The 8'hAA BAT byte is treated as an ordinary byte.
// STRUCTURE
//   ps2_pkg holds:
//   - state enum {IDLE, DATA, PARITY, STOP, ACCEPT};
//   - PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_BAT_OK=8'hAA.
//   Sub-module ps2_line_cond (sync + glitch filter + fall detect) is instantiated once.
//   The FSM, shifter, timeout counter and prefix tracking stay in the top.
// TESTING
//   (1) Frame for 8'h1C, valid parity.
//       -> one code_valid pulse, keycode=1C, is_break=0, is_extended=0, frame_err=0.
//   (2) Frames F0 then 1C.
//       -> 2 pulses: keycode=F0 (is_break=0), then keycode=1C with is_break=1.
//       -> a following 1C gives is_break=0.
//   (3) Frames E0, F0, 75.
//       -> last pulse: keycode=75, is_break=1, is_extended=1.
//   (4) Frame for 8'h32 with flipped parity bit.
//       -> frame_err pulse, no code_valid, keycode keeps its prior value.
//   (5) Stop 4 bits into a frame for >TIMEOUT_US.
//       -> frame_err pulse, FSM back to IDLE.
//       -> next good frame 8'h21 is accepted cleanly.
//   (6) 3-cycle kbdclk glitch (< FILTER_LEN) during IDLE -> no state change.
//       Also assert rst mid-frame -> all outputs 0 and the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receive path.
package ps2_pkg;

    // Receive FSM states; encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        ACCEPT = 3'd4
    } state_t;

    // Well-known scan-code bytes.
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// Conditions the raw PS/2 lines: 2-FF synchronisers on both lines, a
// level filter on the clock line and a one-cycle pulse on its falling edge.
module ps2_line_cond #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic kbdclk,
    input  logic kbddat,
    output logic dat,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [CW-1:0] flt_cnt;

    // Bring both asynchronous lines into the clk domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], kbdclk};
            dat_sync <= {dat_sync[0], kbddat};
        end
    end

    // Accept a new kbdclk level only after FILTER_LEN consecutive equal samples;
    // a filtered 1->0 transition produces the fall pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign dat = dat_sync[1];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receive stage: frames 11-bit device-to-host packets, checks
// odd parity and the stop bit, enforces an inter-edge timeout and tags bytes
// that follow break (F0) or extended (E0) prefixes.
// Output protocol: code_valid is a one-cycle strobe with no back-pressure;
// keycode/is_break/is_extended are held levels that change only with it.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [7:0] keycode,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    // Cycles allowed between falls inside a frame; split to stay within 32 bits.
    localparam int TO_CYCLES = (TIMEOUT_US * (CLK_HZ / 1000)) / 1000;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    logic          dat;
    logic          fall;
    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          brk_pend;
    logic          ext_pend;

    ps2_line_cond #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_cond (
        .clk    (clk),
        .rst    (rst),
        .kbdclk (kbdclk),
        .kbddat (kbddat),
        .dat    (dat),
        .fall   (fall)
    );

    assign timeout   = (to_cnt == TW'(TO_CYCLES));
    assign state_dbg = state;

    // Inter-edge timer: cleared by every fall and while idle, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || fall) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame FSM with shifter, error detection and prefix tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            par         <= 1'b0;
            keycode     <= 8'h00;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            // A fall in the same cycle as the timeout keeps the frame alive.
            if ((state == DATA || state == PARITY || state == STOP) && !fall && timeout) begin
                frame_err <= 1'b1;
                brk_pend  <= 1'b0;
                ext_pend  <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // A high start bit is just line noise: stay idle quietly.
                        if (fall && !dat) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall) begin
                            shift   <= {dat, shift[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall) begin
                            par   <= dat;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall) begin
                            if (dat && odd_parity_ok(shift, par)) begin
                                // Outputs register here so code_valid is high during ACCEPT.
                                keycode    <= shift;
                                code_valid <= 1'b1;
                                if (shift == PS2_BREAK) begin
                                    brk_pend    <= 1'b1;
                                    is_break    <= 1'b0;
                                    is_extended <= ext_pend;
                                end else if (shift == PS2_EXT) begin
                                    ext_pend    <= 1'b1;
                                    is_break    <= 1'b0;
                                    is_extended <= 1'b0;
                                end else begin
                                    is_break    <= brk_pend;
                                    is_extended <= ext_pend;
                                    brk_pend    <= 1'b0;
                                    ext_pend    <= 1'b0;
                                end
                                state <= ACCEPT;
                            end else begin
                                frame_err <= 1'b1;
                                brk_pend  <= 1'b0;
                                ext_pend  <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    ACCEPT: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: drives PS/2 frames bit by bit and
// compares every code_valid strobe against an expected queue.
module tb_ps2_scan_rx;

    localparam int HALF_BIT = 20;

    logic       clk;
    logic       rst;
    logic       kbdclk;
    logic       kbddat;
    logic [7:0] keycode;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
    logic [2:0] state_dbg;

    // Expected {is_extended, is_break, keycode} per accepted byte.
    logic [9:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int err_exp  = 0;

    ps2_scan_rx #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200),
        .FILTER_LEN (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kbdclk      (kbdclk),
        .kbddat      (kbddat),
        .keycode     (keycode),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .frame_err   (frame_err),
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while the clock is high, device pulls the clock low.
    task automatic send_bit(input logic b);
        kbddat = b;
        wait_cycles(HALF_BIT);
        kbdclk = 1'b0;
        wait_cycles(HALF_BIT);
        kbdclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flip_par);
        send_bit(1'b1);
        kbddat = 1'b1;
        wait_cycles(2 * HALF_BIT);
    endtask

    // Good frame whose decoded flags are given explicitly.
    task automatic send_good(input logic [7:0] b, input logic brk, input logic ext);
        exp_q.push_back({ext, brk, b});
        send_frame(b, 1'b0);
    endtask

    // Scoreboard: compare each strobe with the queue head, count error pulses.
    always @(negedge clk) begin
        if (code_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code_valid", {22'd0, is_extended, is_break, keycode}, 32'hFFFF_FFFF);
            end else begin
                check("code", {22'd0, is_extended, is_break, keycode}, {22'd0, exp_q.pop_front()});
            end
        end
        if (frame_err) err_seen++;
    end

    initial begin
        int bad_state;
        rst    = 1'b1;
        kbdclk = 1'b1;
        kbddat = 1'b1;
        wait_cycles(5);
        check("rst_keycode", {24'd0, keycode}, 32'h00);
        check("rst_code_valid", {31'd0, code_valid}, 0);
        check("rst_is_break", {31'd0, is_break}, 0);
        check("rst_is_extended", {31'd0, is_extended}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_state", {29'd0, state_dbg}, 0);
        rst = 1'b0;
        wait_cycles(5);

        // (1) plain make code
        send_good(8'h1C, 1'b0, 1'b0);
        check("t1_keycode", {24'd0, keycode}, 32'h1C);

        // (2) break sequence, then a plain repeat
        send_good(8'hF0, 1'b0, 1'b0);
        send_good(8'h1C, 1'b1, 1'b0);
        send_good(8'h1C, 1'b0, 1'b0);

        // (3) extended break: F0 carries the pending extended flag
        send_good(8'hE0, 1'b0, 1'b0);
        send_good(8'hF0, 1'b0, 1'b1);
        send_good(8'h75, 1'b1, 1'b1);
        check("t3_is_break", {31'd0, is_break}, 1);
        check("t3_is_extended", {31'd0, is_extended}, 1);

        // (4) bad parity: error pulse, held outputs untouched
        send_frame(8'h32, 1'b1);
        err_exp++;
        check("t4_err_cnt", err_seen, err_exp);
        check("t4_keycode_held", {24'd0, keycode}, 32'h75);
        check("t4_flags_held", {30'd0, is_extended, is_break}, 32'h3);

        // An error after F0 drops the pending break flag; AA is ordinary
        send_good(8'hF0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1);
        err_exp++;
        send_good(8'hAA, 1'b0, 1'b0);
        check("t4b_err_cnt", err_seen, err_exp);

        // (5) abandon a frame after four bits: timeout error, then recover
        for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        wait_cycles(300);
        err_exp++;
        check("t5_err_cnt", err_seen, err_exp);
        check("t5_state_idle", {29'd0, state_dbg}, 0);
        send_good(8'h21, 1'b0, 1'b0);
        check("t5_keycode", {24'd0, keycode}, 32'h21);

        // (6) short kbdclk glitch while idle must not move the FSM
        kbddat = 1'b0;
        kbdclk = 1'b0;
        wait_cycles(3);
        kbdclk = 1'b1;
        bad_state = 0;
        for (int i = 0; i < 30; i++) begin
            wait_cycles(1);
            if (state_dbg != 3'd0) bad_state++;
        end
        kbddat = 1'b1;
        check("t6_glitch_state", bad_state, 0);

        // Reset mid-frame discards the partial byte
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        rst = 1'b1;
        wait_cycles(3);
        check("t6_rst_keycode", {24'd0, keycode}, 32'h00);
        check("t6_rst_state", {29'd0, state_dbg}, 0);
        check("t6_rst_flags", {29'd0, code_valid, is_break, is_extended}, 0);
        rst = 1'b0;
        wait_cycles(5);
        send_good(8'h1C, 1'b0, 1'b0);
        check("t6_keycode", {24'd0, keycode}, 32'h1C);

        wait_cycles(50);
        check("final_err_cnt", err_seen, err_exp);
        check("frames_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
